// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: pin command encodings
// {cs_n, ras_n, cas_n, we_n} and the arbiter state encoding.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// Command arbiter: holds traffic until init completes, then grants one engine
// at a time (refresh > write > read) and muxes its bus onto the SDRAM pins.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DQ_W   = 16
) (
    input  logic              sclk,
    input  logic              snrst,

    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,

    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,

    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              wr_dq_oe,

    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,

    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,

    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   dq_out,
    output logic              dq_oe
);

    arb_state_t state;
    arb_state_t next_state;

    // Clock is never gated by this controller.
    assign sdram_cke = 1'b1;

    // Grants decode next_state so they rise together with the state change
    // and drop on the same edge the FSM returns to ARBIT.
    // NOTE: non-blocking assignments for all registered state, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge sclk) begin
        if (snrst) begin
            state   <= INIT;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            state   <= next_state;
            aref_en <= (next_state == AREF);
            wr_en   <= (next_state == WRITE);
            rd_en   <= (next_state == READ);
        end
    end

    // End pulses are only honoured by the state that owns them; no preemption.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            INIT:  if (init_end) next_state = ARBIT;
            ARBIT: begin
                if (aref_req)    next_state = AREF;
                else if (wr_req) next_state = WRITE;
                else if (rd_req) next_state = READ;
            end
            AREF:  if (aref_end) next_state = ARBIT;
            WRITE: if (wr_end)   next_state = ARBIT;
            READ:  if (rd_end)   next_state = ARBIT;
            default:             next_state = INIT;
        endcase
    end

    // Pin mux on the registered state; Dq is only ever driven while writing.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_ba   = '0;
        sdram_addr = '0;
        dq_out     = '0;
        dq_oe      = 1'b0;
        case (state)
            INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
                dq_out     = wr_dq;
                dq_oe      = wr_dq_oe;
            end
            READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: stimulus queues the expected grant/pin
// snapshot for each grant change; a negedge monitor pops and compares.
module tb_sdram_arbit;

    logic        sclk = 1'b0;
    logic        snrst;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic [15:0] wr_dq;
    logic        wr_dq_oe;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        aref_en, wr_en, rd_en;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] dq_out;
    logic        dq_oe;

    sdram_arbit #(.ADDR_W(13), .BA_W(2), .DQ_W(16)) dut (
        .sclk(sclk), .snrst(snrst),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
        .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba),
        .sdram_addr(sdram_addr), .dq_out(dq_out), .dq_oe(dq_oe)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [2:0]  gnt;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [15:0] dq;
        logic        oe;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic push(input int c, input logic [2:0] g, input logic [3:0] cmd,
                        input logic [1:0] ba, input logic [12:0] addr,
                        input logic [15:0] dq, input logic oe);
        exp_t e;
        e.cyc = c; e.gnt = g; e.cmd = cmd; e.ba = ba; e.addr = addr; e.dq = dq; e.oe = oe;
        exp_q.push_back(e);
    endtask

    // Expected snapshots, hand-written from the engine bus constants below.
    task automatic ev_nop(input int c);  push(c, 3'b000, 4'b0111, 2'd0, 13'h0000, 16'h0000, 1'b0); endtask
    task automatic ev_aref(input int c); push(c, 3'b100, 4'b0001, 2'd0, 13'h0000, 16'h0000, 1'b0); endtask
    task automatic ev_wr(input int c);   push(c, 3'b010, 4'b0100, 2'd2, 13'h0123, 16'hA5A5, 1'b1); endtask
    task automatic ev_rd(input int c);   push(c, 3'b001, 4'b0101, 2'd3, 13'h0ABC, 16'h0000, 1'b0); endtask

    // Monitor: every change of the grant vector is a DUT event to score.
    logic [2:0] prev_gnt = 3'b000;
    always @(negedge sclk) begin
        logic [2:0] cur;
        exp_t e;
        if (mon_en) begin
            cur = {aref_en, wr_en, rd_en};
            if (cur !== prev_gnt) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_gnt_change", {61'd0, cur}, {61'd0, prev_gnt});
                end else begin
                    e = exp_q.pop_front();
                    check("ev_cycle", cyc, e.cyc);
                    check("ev_gnt",   {61'd0, cur}, {61'd0, e.gnt});
                    check("ev_cmd",   {60'd0, sdram_cmd}, {60'd0, e.cmd});
                    check("ev_ba_addr", {49'd0, sdram_ba, sdram_addr}, {49'd0, e.ba, e.addr});
                    check("ev_dq",    {48'd0, dq_out}, {48'd0, e.dq});
                    check("ev_oe",    {63'd0, dq_oe}, {63'd0, e.oe});
                end
                prev_gnt = cur;
            end
        end
    end

    int c;

    initial begin
        snrst = 1'b1; init_end = 1'b0;
        init_cmd = 4'b0010; init_ba = 2'd1; init_addr = 13'h0400;
        aref_req = 1'b0; aref_end = 1'b0; aref_cmd = 4'b0001; aref_ba = 2'd0; aref_addr = 13'h0000;
        wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'd2; wr_addr = 13'h0123;
        wr_dq = 16'hA5A5; wr_dq_oe = 1'b1;
        rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'd3; rd_addr = 13'h0ABC;

        tick(); tick();
        snrst = 1'b0;
        mon_en = 1'b1;

        // Reset / INIT: init bus on pins, no grants, Dq released.
        check("init_cmd",  {60'd0, sdram_cmd}, 64'h2);
        check("init_gnt",  {61'd0, aref_en, wr_en, rd_en}, 64'h0);
        check("init_oe",   {63'd0, dq_oe}, 64'h0);
        check("init_dq",   {48'd0, dq_out}, 64'h0);
        check("init_cke",  {63'd0, sdram_cke}, 64'h1);
        repeat (100) tick();
        check("init_hold_cmd", {60'd0, sdram_cmd}, 64'h2);
        check("init_hold_ba_addr", {49'd0, sdram_ba, sdram_addr}, {49'd0, 2'd1, 13'h0400});
        check("init_hold_gnt", {61'd0, aref_en, wr_en, rd_en}, 64'h0);

        // Init done with a write pending: one ARBIT cycle, then wr_en.
        c = cyc; init_end = 1'b1; wr_req = 1'b1;
        ev_wr(c + 2);
        tick();
        check("arbit_nop_cmd", {60'd0, sdram_cmd}, 64'h7);
        check("arbit_oe", {63'd0, dq_oe}, 64'h0);
        tick();
        wr_req = 1'b0;
        init_end = 1'b0;            // must be ignored from now on
        tick();
        rd_end = 1'b1;              // stray pulse, not owned by WRITE
        tick();
        rd_end = 1'b0;
        tick();
        c = cyc; wr_end = 1'b1; ev_nop(c + 1);
        tick(); wr_end = 1'b0;

        // All three requests: AREF, then WRITE, then READ, NOP between each.
        c = cyc; aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        ev_aref(c + 1);
        tick(); aref_req = 1'b0;
        repeat (3) tick();
        c = cyc; aref_end = 1'b1; ev_nop(c + 1); ev_wr(c + 2);
        tick(); aref_end = 1'b0;
        tick(); wr_req = 1'b0;
        repeat (2) tick();
        c = cyc; wr_end = 1'b1; ev_nop(c + 1); ev_rd(c + 2);
        tick(); wr_end = 1'b0;
        tick(); rd_req = 1'b0;
        check("read_oe", {63'd0, dq_oe}, 64'h0);

        // Refresh request during READ: no preemption, AREF 2 cycles after rd_end.
        tick(); aref_req = 1'b1;
        repeat (3) tick();
        c = cyc; rd_end = 1'b1; ev_nop(c + 1); ev_aref(c + 2);
        tick(); rd_end = 1'b0;
        tick(); aref_req = 1'b0;
        tick();
        c = cyc; aref_end = 1'b1; ev_nop(c + 1);
        tick(); aref_end = 1'b0;

        // Reset mid-write: grants drop and Dq releases on the next edge.
        c = cyc; wr_req = 1'b1; ev_wr(c + 1);
        tick(); wr_req = 1'b0;
        tick();
        check("write_oe", {63'd0, dq_oe}, 64'h1);
        check("write_dq", {48'd0, dq_out}, 64'hA5A5);
        c = cyc; snrst = 1'b1;
        init_cmd = 4'b0111; init_ba = 2'd0; init_addr = 13'h0000;
        ev_nop(c + 1);
        tick(); snrst = 1'b0; wr_req = 1'b1;
        check("rst_cmd", {60'd0, sdram_cmd}, 64'h7);
        check("rst_oe",  {63'd0, dq_oe}, 64'h0);
        check("rst_wr_en", {63'd0, wr_en}, 64'h0);
        repeat (5) tick();
        check("rst_hold_wr_en", {63'd0, wr_en}, 64'h0);
        c = cyc; init_end = 1'b1; ev_wr(c + 2);
        tick(); tick(); wr_req = 1'b0;
        tick();
        c = cyc; wr_end = 1'b1; ev_nop(c + 1);
        tick(); wr_end = 1'b0;

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
